led_panel_scan_ctrl: RTL

//  Scan controller for the 32x16 RGB LED panel. Walks a double-buffered

---
 rtl/led_panel_scan_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/led_panel_scan_ctrl.sv
// Scan controller for a 32x16 RGB LED panel: walks a double-buffered framebuffer
// row pair by row pair and bit plane by bit plane using binary-code modulation.
module led_panel_scan_ctrl #(
  parameter int COLS       = 32,
  parameter int ROW_ADDR_W = 3,
  parameter int BPP        = 4,
  parameter int CLK_DIV    = 2,
  parameter int BASE_TICKS = 16
) (
  input  logic                              sysclk,
  input  logic                              sysreset,
  input  logic                              enable,
  input  logic                              swap_req,
  output logic                              swap_ack,
  output logic                              buf_sel,
  output logic                              frame_done,
  output logic                              fb_rd_en,
  output logic [ROW_ADDR_W+$clog2(COLS):0]  fb_addr,
  input  logic [6*BPP-1:0]                  fb_rd_data,
  output logic [2:0]                        led_rgb1,
  output logic [2:0]                        led_rgb2,
  output logic [ROW_ADDR_W-1:0]             led_abc,
  output logic                              led_clk,
  output logic                              led_latch,
  output logic                              led_oe
);

  localparam int COL_W   = $clog2(COLS);
  localparam int CYC_W   = $clog2(2 * CLK_DIV);
  localparam int PLANE_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int TICK_W  = $clog2(BASE_TICKS << (BPP - 1)) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_e;

  state_e                 state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic [ROW_ADDR_W-1:0]  row_q, row_d;
  logic [PLANE_W-1:0]     plane_q, plane_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic                   buf_sel_q, buf_sel_d;
  logic [2:0]             rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic [ROW_ADDR_W-1:0]  abc_q, abc_d;

  logic [BPP-1:0] chan [6];
  logic [2:0]     pix_top, pix_bot;
  logic           col_last, cyc_last, plane_last, row_last, tick_last, rgb_load;

  // Channels in fb_rd_data order: top r/g/b, then bottom r/g/b.
  always_comb begin
    for (int i = 0; i < 6; i++) chan[i] = fb_rd_data[(5 - i) * BPP +: BPP];
    pix_top = {chan[0][plane_q], chan[1][plane_q], chan[2][plane_q]};
    pix_bot = {chan[3][plane_q], chan[4][plane_q], chan[5][plane_q]};
  end

  assign col_last   = (col_q == COL_W'(COLS - 1));
  assign cyc_last   = (cyc_q == CYC_W'(2 * CLK_DIV - 1));
  assign plane_last = (plane_q == PLANE_W'(BPP - 1));
  assign row_last   = &row_q;
  assign tick_last  = (tick_q == TICK_W'((BASE_TICKS << plane_q) - 1));
  assign rgb_load   = (state_q == SHIFT) && (cyc_q == CYC_W'(1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cyc_d      = cyc_q;
    row_d      = row_q;
    plane_d    = plane_q;
    tick_d     = tick_q;
    buf_sel_d  = buf_sel_q;
    rgb1_d     = rgb1_q;
    rgb2_d     = rgb2_q;
    abc_d      = abc_q;
    led_oe     = 1'b1;
    led_clk    = 1'b0;
    led_latch  = 1'b0;
    fb_rd_en   = 1'b0;
    frame_done = 1'b0;
    swap_ack   = 1'b0;

    unique case (state_q)
      IDLE: begin
        col_d   = '0;
        cyc_d   = '0;
        row_d   = '0;
        plane_d = '0;
        tick_d  = '0;
        if (enable) state_d = SHIFT;
      end

      SHIFT: begin
        led_clk  = (cyc_q >= CYC_W'(CLK_DIV));
        fb_rd_en = (cyc_q == '0);
        if (rgb_load) begin
          rgb1_d = pix_top;
          rgb2_d = pix_bot;
        end
        cyc_d = cyc_q + 1'b1;
        if (cyc_last) begin
          cyc_d = '0;
          col_d = col_q + 1'b1;
          if (col_last) state_d = LATCH;
        end
      end

      LATCH: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == '0) begin
          led_latch = 1'b1;
          abc_d     = row_q;
        end else begin
          cyc_d   = '0;
          tick_d  = '0;
          state_d = DISPLAY;
        end
      end

      DISPLAY: begin
        led_oe  = 1'b0;
        tick_d  = tick_q + 1'b1;
        if (tick_last) begin
          tick_d  = '0;
          state_d = SHIFT;
          if (!plane_last) begin
            plane_d = plane_q + 1'b1;
          end else begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
            if (row_last) begin
              // Only the frame boundary may swap buffers or stop scanning.
              frame_done = 1'b1;
              swap_ack   = swap_req;
              if (swap_req) buf_sel_d = ~buf_sel_q;
              state_d = enable ? SHIFT : IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      cyc_q     <= '0;
      row_q     <= '0;
      plane_q   <= '0;
      tick_q    <= '0;
      buf_sel_q <= 1'b0;
      rgb1_q    <= '0;
      rgb2_q    <= '0;
      abc_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cyc_q     <= cyc_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      tick_q    <= tick_d;
      buf_sel_q <= buf_sel_d;
      rgb1_q    <= rgb1_d;
      rgb2_q    <= rgb2_d;
      abc_q     <= abc_d;
    end
  end

  // Pixel bits are passed through in the capture cycle so they are valid before led_clk rises.
  assign led_rgb1 = rgb_load ? pix_top : rgb1_q;
  assign led_rgb2 = rgb_load ? pix_bot : rgb2_q;
  assign led_abc  = abc_q;
  assign buf_sel  = buf_sel_q;
  assign fb_addr  = fb_rd_en ? {buf_sel_q, row_q, col_q} : '0;

endmodule
